// File: rtl/rv32i_package.sv
// Shared types and constants for the rv32i decode stage: operand selects,
// ALU operations, immediate formats and base opcodes.
package rv32i_package;

  typedef enum logic [1:0] {SRC_0 = 2'd0, SRC_PC = 2'd1, SRC_RS1 = 2'd2} alu_op_a_t;
  typedef enum logic [1:0] {SRC_4 = 2'd0, SRC_IMM = 2'd1, SRC_RS2 = 2'd2} alu_op_b_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_OR, ALU_AND, ALU_SL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // alt selects the funct7[5] variant: SUB for funct3 000, SRA for funct3 101.
  function automatic alu_op_t funct3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: assembles and sign-extends the
// immediate of the selected instruction format.
module rv32i_imm_gen
  import rv32i_package::*;
(
  input  logic [31:0] instr,
  input  imm_type_t   imm_type,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode.sv
// rv32i decode stage: decodes the fetched instruction into ALU/memory/branch
// controls and registers them, handling stall, flush and load-use bubbles.
module rv32i_decode
  import rv32i_package::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        decode_stall,
  input  logic        flush,
  output logic        decode_valid,
  output logic [31:0] pc,
  output alu_op_a_t   alu_op_a,
  output alu_op_b_t   alu_op_b,
  output alu_op_t     alu_op,
  output logic [31:0] imm_value,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        rd_we,
  output logic        is_load,
  output logic        is_store,
  output logic [2:0]  mem_size,
  output logic        is_branch,
  output logic [2:0]  branch_cond,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        illegal_instr
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  imm_type_t   imm_type;
  logic [31:0] imm;
  alu_op_a_t   dec_op_a;
  alu_op_b_t   dec_op_b;
  alu_op_t     dec_alu;
  logic        dec_we, dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_illegal;
  logic        reads_rs1, reads_rs2, hazard;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  rv32i_imm_gen u_imm_gen (
    .instr    (instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  always_comb begin
    dec_op_a    = SRC_RS1;
    dec_op_b    = SRC_IMM;
    dec_alu     = ALU_ADD;
    imm_type    = IMM_I;
    dec_we      = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_branch  = 1'b0;
    dec_jal     = 1'b0;
    dec_jalr    = 1'b0;
    dec_illegal = 1'b0;
    reads_rs1   = 1'b0;
    reads_rs2   = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec_op_a = SRC_0;  imm_type = IMM_U; dec_we = 1'b1; end
      OPC_AUIPC: begin dec_op_a = SRC_PC; imm_type = IMM_U; dec_we = 1'b1; end
      OPC_JAL: begin
        dec_op_a = SRC_PC; dec_op_b = SRC_4; imm_type = IMM_J;
        dec_we = 1'b1; dec_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_op_a = SRC_PC; dec_op_b = SRC_4; imm_type = IMM_I;
        dec_we = 1'b1; dec_jalr = 1'b1; reads_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_op_b = SRC_RS2; dec_alu = ALU_SUB; imm_type = IMM_B;
        dec_branch = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1;
        dec_illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD:  begin dec_load = 1'b1; dec_we = 1'b1; reads_rs1 = 1'b1; end
      OPC_STORE: begin
        imm_type = IMM_S; dec_store = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // The upper immediate bits double as funct7 only for the shifts.
        dec_alu = funct3_to_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        dec_we = 1'b1; reads_rs1 = 1'b1;
        dec_illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                      ((funct3 == 3'b101) && ((funct7 & 7'h5F) != 7'h00));
      end
      OPC_OP: begin
        dec_op_b = SRC_RS2;
        dec_alu = funct3_to_alu(funct3, funct7[5]);
        dec_we = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1;
        dec_illegal = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: ;
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_we     = 1'b0;
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_branch = 1'b0;
      dec_jal    = 1'b0;
      dec_jalr   = 1'b0;
    end
  end

  // rd_we already excludes x0, so a load to x0 never interlocks.
  assign hazard = decode_valid && is_load && rd_we &&
                  ((reads_rs1 && (instr[19:15] == rd_addr)) ||
                   (reads_rs2 && (instr[24:20] == rd_addr)));
  assign instr_ready = !decode_stall && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      decode_valid  <= 1'b0;
      pc            <= 32'd0;
      alu_op_a      <= SRC_0;
      alu_op_b      <= SRC_IMM;
      alu_op        <= ALU_ADD;
      imm_value     <= 32'd0;
      rs1_addr      <= 5'd0;
      rs2_addr      <= 5'd0;
      rd_addr       <= 5'd0;
      rd_we         <= 1'b0;
      is_load       <= 1'b0;
      is_store      <= 1'b0;
      mem_size      <= 3'd0;
      is_branch     <= 1'b0;
      branch_cond   <= 3'd0;
      is_jal        <= 1'b0;
      is_jalr       <= 1'b0;
      illegal_instr <= 1'b0;
    end else if (flush) begin
      decode_valid <= 1'b0;
      rd_we        <= 1'b0;
      is_load      <= 1'b0;
      is_store     <= 1'b0;
      is_branch    <= 1'b0;
      is_jal       <= 1'b0;
      is_jalr      <= 1'b0;
    end else if (decode_stall) begin
    end else if (hazard) begin
      decode_valid <= 1'b0;
      rd_we        <= 1'b0;
      is_load      <= 1'b0;
    end else if (instr_valid) begin
      decode_valid  <= 1'b1;
      pc            <= instr_pc;
      alu_op_a      <= dec_op_a;
      alu_op_b      <= dec_op_b;
      alu_op        <= dec_alu;
      imm_value     <= imm;
      rs1_addr      <= instr[19:15];
      rs2_addr      <= instr[24:20];
      rd_addr       <= instr[11:7];
      rd_we         <= dec_we && (instr[11:7] != 5'd0);
      is_load       <= dec_load;
      is_store      <= dec_store;
      mem_size      <= funct3;
      is_branch     <= dec_branch;
      branch_cond   <= funct3;
      is_jal        <= dec_jal;
      is_jalr       <= dec_jalr;
      illegal_instr <= dec_illegal;
    end else begin
      decode_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_decode.sv
// Scoreboard bench for rv32i_decode: directed test-plan instructions followed
// by randomized instructions, stalls, flushes and resets against a reference model.
module tb_rv32i_decode;
  import rv32i_package::*;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, decode_stall, flush, decode_valid;
  logic [31:0] instr, instr_pc, pc, imm_value;
  alu_op_a_t   alu_op_a;
  alu_op_b_t   alu_op_b;
  alu_op_t     alu_op;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we, is_load, is_store, is_branch, is_jal, is_jalr, illegal_instr;
  logic [2:0]  mem_size, branch_cond;

  rv32i_decode dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .decode_stall(decode_stall), .flush(flush), .decode_valid(decode_valid),
    .pc(pc), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op),
    .imm_value(imm_value), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_we(rd_we), .is_load(is_load), .is_store(is_store),
    .mem_size(mem_size), .is_branch(is_branch), .branch_cond(branch_cond),
    .is_jal(is_jal), .is_jalr(is_jalr), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, imm;
    alu_op_a_t   a;
    alu_op_b_t   b;
    alu_op_t     op;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ld, st, br, jal, jalr, ill;
    logic [2:0]  f3;
    bit          alu_chk, imm_chk;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   model_known = 0;
  exp_t cur;
  exp_t sb[$];

  localparam int NCYC = 1500;
  localparam int NDIR = 16;
  logic [31:0] dir_instr [NDIR] = '{
    32'hFFF10093, 32'h402081B3, 32'h40325213, 32'hFFDFF06F,
    32'h0000A283, 32'h00028333, 32'h0000A283, 32'h00512023,
    32'h0000A003, 32'h00000333, 32'h00000073, 32'h023100B3,
    32'hFFF10093, 32'h402081B3, 32'h0000A283, 32'h00028333};
  // 0 run, 1 stall, 2 flush+stall, 3 reset
  int dir_ctrl [32] = '{3,3,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,0,2,0,0,0,0,3,0,0,0,0,0,0,0,0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_opc(input logic [6:0] o, input logic [6:0] want);
    return o == want;
  endfunction

  function automatic bit hz(input exp_t c, input logic [31:0] i);
    logic [6:0] o;
    bit r1, r2;
    o  = i[6:0];
    r1 = is_opc(o, OPC_JALR) || is_opc(o, OPC_BRANCH) || is_opc(o, OPC_LOAD) ||
         is_opc(o, OPC_STORE) || is_opc(o, OPC_OP_IMM) || is_opc(o, OPC_OP);
    r2 = is_opc(o, OPC_BRANCH) || is_opc(o, OPC_STORE) || is_opc(o, OPC_OP);
    return c.valid && c.ld && c.we && ((r1 && i[19:15] == c.rd) || (r2 && i[24:20] == c.rd));
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    int sx;
    logic [6:0] f7;
    logic we;
    alu_op_t tbl [8];
    tbl = '{ALU_ADD, ALU_SL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    sx = $signed(i);
    f7 = i[31:25];
    e.valid = 1; e.pc = p; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.f3 = i[14:12]; e.a = SRC_RS1; e.b = SRC_IMM; e.op = ALU_ADD;
    e.imm = 32'(sx >>> 20);
    e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0; e.ill = 0; we = 0;
    e.alu_chk = 1; e.imm_chk = 1;
    case (i[6:0])
      OPC_LUI:   begin e.a = SRC_0;  e.imm = i & 32'hFFFFF000; we = 1; end
      OPC_AUIPC: begin e.a = SRC_PC; e.imm = i & 32'hFFFFF000; we = 1; end
      OPC_JAL: begin
        e.a = SRC_PC; e.b = SRC_4; we = 1; e.jal = 1;
        e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      OPC_JALR: begin e.a = SRC_PC; e.b = SRC_4; we = 1; e.jalr = 1; end
      OPC_BRANCH: begin
        e.b = SRC_RS2; e.op = ALU_SUB; e.br = 1;
        e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        if (e.f3 == 3'd2 || e.f3 == 3'd3) e.ill = 1;
      end
      OPC_LOAD:  begin e.ld = 1; we = 1; end
      OPC_STORE: begin e.st = 1; e.imm = (32'(sx >>> 25) << 5) | {27'd0, i[11:7]}; end
      OPC_OP_IMM: begin
        we = 1;
        e.op = tbl[e.f3];
        if (e.f3 == 3'd1 && f7 != 0) e.ill = 1;
        if (e.f3 == 3'd5) begin
          if (f7 == 7'h20) e.op = ALU_SRA;
          else if (f7 != 0) e.ill = 1;
        end
      end
      OPC_OP: begin
        we = 1; e.b = SRC_RS2; e.imm_chk = 0;
        if (f7 == 0) e.op = tbl[e.f3];
        else if (f7 == 7'h20 && e.f3 == 3'd0) e.op = ALU_SUB;
        else if (f7 == 7'h20 && e.f3 == 3'd5) e.op = ALU_SRA;
        else e.ill = 1;
      end
      OPC_MISC_MEM: begin e.alu_chk = 0; e.imm_chk = 0; end
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      we = 0; e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0;
      e.alu_chk = 0; e.imm_chk = 0;
    end
    e.we = we && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                              OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};
    logic [6:0] f7s [4];
    int k;
    logic [6:0] o;
    f7s = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
    k = $urandom_range(0, 13);
    o = (k < 11) ? opcs[k] : ((k == 11) ? OPC_LOAD : 7'($urandom));
    return {f7s[$urandom_range(0, 3)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), o};
  endfunction

  task automatic compare_full(input exp_t e);
    chk("decode_valid", 32'(decode_valid), 32'(e.valid));
    chk("pc", pc, e.pc);
    chk("rs1_addr", 32'(rs1_addr), 32'(e.rs1));
    chk("rs2_addr", 32'(rs2_addr), 32'(e.rs2));
    chk("rd_addr", 32'(rd_addr), 32'(e.rd));
    chk("rd_we", 32'(rd_we), 32'(e.we));
    chk("is_load", 32'(is_load), 32'(e.ld));
    chk("is_store", 32'(is_store), 32'(e.st));
    chk("is_branch", 32'(is_branch), 32'(e.br));
    chk("is_jal", 32'(is_jal), 32'(e.jal));
    chk("is_jalr", 32'(is_jalr), 32'(e.jalr));
    chk("illegal_instr", 32'(illegal_instr), 32'(e.ill));
    if (e.alu_chk) begin
      chk("alu_op_a", 32'(alu_op_a), 32'(e.a));
      chk("alu_op_b", 32'(alu_op_b), 32'(e.b));
      chk("alu_op", 32'(alu_op), 32'(e.op));
    end
    if (e.imm_chk) chk("imm_value", imm_value, e.imm);
    if (e.ld || e.st) chk("mem_size", 32'(mem_size), 32'(e.f3));
    if (e.br) chk("branch_cond", 32'(branch_cond), 32'(e.f3));
  endtask

  task automatic check_reset_values();
    chk("rst_decode_valid", 32'(decode_valid), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_alu_op_a", 32'(alu_op_a), 32'(SRC_0));
    chk("rst_alu_op_b", 32'(alu_op_b), 32'(SRC_IMM));
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst_imm_value", imm_value, 32'd0);
    chk("rst_regs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
    chk("rst_flags", {23'd0, rd_we, is_load, is_store, is_branch, is_jal, is_jalr,
                      illegal_instr, 2'b00}, 32'd0);
    chk("rst_f3", {26'd0, mem_size, branch_cond}, 32'd0);
  endtask

  // Monitor: classify each edge from its sampled inputs, then check outputs.
  initial begin
    int k;
    exp_t e;
    cur = '{valid: 0, pc: 0, imm: 0, a: SRC_0, b: SRC_IMM, op: ALU_ADD, rs1: 0, rs2: 0,
            rd: 0, we: 0, ld: 0, st: 0, br: 0, jal: 0, jalr: 0, ill: 0, f3: 0,
            alu_chk: 0, imm_chk: 0};
    forever begin
      @(posedge clk);
      if (reset) k = 0;
      else if (flush) k = 1;
      else if (decode_stall) k = 2;
      else if (hz(cur, instr)) k = 3;
      else if (instr_valid) k = 4;
      else k = 5;
      @(negedge clk);
      case (k)
        0: begin
          check_reset_values();
          cur.valid = 0; cur.we = 0; cur.ld = 0;
          model_known = 1;
        end
        1: begin
          chk("flush_valid", 32'(decode_valid), 32'd0);
          chk("flush_flags", {26'd0, rd_we, is_load, is_store, is_branch, is_jal, is_jalr}, 32'd0);
          cur.valid = 0; cur.we = 0; cur.ld = 0; cur.st = 0; cur.br = 0; cur.jal = 0; cur.jalr = 0;
        end
        2: if (cur.valid) compare_full(cur);
           else chk("stall_bubble_valid", 32'(decode_valid), 32'd0);
        3: begin
          chk("hazard_bubble", {29'd0, decode_valid, rd_we, is_load}, 32'd0);
          cur.valid = 0; cur.we = 0; cur.ld = 0;
        end
        4: begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty: got output with no expected entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            $display("txn pc=%h op_a=%0d op_b=%0d op=%0d imm=%h rd=%0d we=%0b ill=%0b",
                     pc, alu_op_a, alu_op_b, alu_op, imm_value, rd_addr, rd_we, illegal_instr);
            compare_full(e);
            cur = e;
          end
        end
        default: begin
          chk("idle_valid", 32'(decode_valid), 32'd0);
          cur.valid = 0;
        end
      endcase
    end
  end

  // Driver: holds each instruction until the model says it was accepted.
  initial begin
    int ctrl, r, dptr;
    bit have, v, exp_ready;
    logic [31:0] cur_i, cur_pc, pc_ctr;
    reset = 1; instr_valid = 0; decode_stall = 0; flush = 0; instr = 0; instr_pc = 0;
    have = 0; dptr = 0; pc_ctr = 32'h1000; cur_i = 0; cur_pc = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk); #1;
      if (cyc < 32) begin
        ctrl = dir_ctrl[cyc]; v = 1;
      end else begin
        r = $urandom_range(0, 99);
        ctrl = (r < 2) ? 3 : (r < 6) ? 2 : (r < 9) ? 4 : (r < 27) ? 1 : 0;
        v = ($urandom_range(0, 99) < 85);
      end
      if (!have) begin
        if (dptr < NDIR) begin cur_i = dir_instr[dptr]; dptr++; end
        else cur_i = rand_instr();
        cur_pc = pc_ctr; pc_ctr += 32'd4; have = 1;
      end
      reset = (ctrl == 3);
      decode_stall = (ctrl == 1 || ctrl == 2);
      flush = (ctrl == 2 || ctrl == 4);
      instr = cur_i; instr_pc = cur_pc; instr_valid = v;
      #1;
      exp_ready = !decode_stall && !flush && !hz(cur, instr);
      if (model_known) chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
      if (v && exp_ready && !reset) begin
        sb.push_back(ref_decode(cur_i, cur_pc));
        have = 0;
      end
    end
    @(negedge clk); #1;
    reset = 0; instr_valid = 0; decode_stall = 0; flush = 0;
    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
